// File: rtl/gb_lcd_frame_writer.sv
// Converts the raw PPU pixel stream into an aligned 160x144 frame-buffer write stream.
// Define GB_LCD_FRAME_WRITER_ERRCNT_EN to add the saturating err_count output.
module gb_lcd_frame_writer #(
  parameter int unsigned H_PIX     = 160,
  parameter int unsigned V_LINES   = 144,
  parameter logic [1:0]  PAD_SHADE = 2'b00,
  parameter int unsigned ADDR_W    = 15
) (
  input  logic              GameBoy_clk,
  input  logic              GameBoy_reset,
  input  logic [1:0]        pix_in,
  input  logic              pix_valid,
  input  logic              line_start,
  input  logic              frame_start,
  input  logic              lcd_en,
  output logic [1:0]        LD,
  output logic              PX_VALID,
  output logic [ADDR_W-1:0] WR_ADDR,
  output logic              frame_done,
  output logic              err_sticky
`ifdef GB_LCD_FRAME_WRITER_ERRCNT_EN
  ,
  output logic [7:0]        err_count
`endif
);

  localparam int unsigned XW = $clog2(H_PIX + 1);
  localparam int unsigned YW = $clog2(V_LINES + 1);
  localparam logic [XW-1:0]     LP_X_END  = XW'(H_PIX);
  localparam logic [XW-1:0]     LP_X_LAST = XW'(H_PIX - 1);
  localparam logic [XW-1:0]     LP_X_ONE  = XW'(1);
  localparam logic [YW-1:0]     LP_Y_LAST = YW'(V_LINES - 1);
  localparam logic [YW-1:0]     LP_Y_ONE  = YW'(1);
  localparam logic [ADDR_W-1:0] LP_A_LAST = ADDR_W'(H_PIX * V_LINES - 1);
  localparam logic [ADDR_W-1:0] LP_A_ONE  = ADDR_W'(1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACTIVE = 2'd1;
  localparam logic [1:0] S_PAD    = 2'd2;
  localparam logic [1:0] S_BLANK  = 2'd3;

  logic [1:0]        r_state;
  logic [XW-1:0]     r_x;
  logic [YW-1:0]     r_y;
  logic [ADDR_W-1:0] r_addr;
  logic              r_lcd_q;
  logic              r_done_pend;
  logic [1:0]        r_ld;
  logic              r_px_valid;
  logic [ADDR_W-1:0] r_wr_addr;
  logic              r_frame_done;
  logic              r_err_sticky;

  logic          w_fall;
  logic          w_take;
  logic          w_drop;
  logic          w_short;
  logic          w_pad_entry;
  logic          w_line_full;
  logic          w_frame_full;
  logic          w_err_evt;
  logic [XW-1:0] w_x_nxt;

  // The pixel is applied first; line_start then sees the post-pixel x.
  always_comb begin
    w_fall       = r_lcd_q & ~lcd_en;
    w_take       = (r_state == S_ACTIVE) && pix_valid && (r_x != LP_X_END);
    w_x_nxt      = w_take ? (r_x + LP_X_ONE) : r_x;
    w_line_full  = (w_x_nxt == LP_X_END);
    w_frame_full = w_take && w_line_full && (r_y == LP_Y_LAST);
    w_short      = frame_start && ((r_state == S_ACTIVE) || (r_state == S_PAD));
    w_drop       = pix_valid && (((r_state == S_ACTIVE) && !w_take) || (r_state == S_PAD));
    w_pad_entry  = (r_state == S_ACTIVE) && line_start && !w_line_full && (w_x_nxt != '0);
    w_err_evt    = !w_fall && (w_short || w_drop || w_pad_entry);
  end

  always_ff @(posedge GameBoy_clk or posedge GameBoy_reset) begin
    if (GameBoy_reset) begin
      r_state      <= S_IDLE;
      r_x          <= '0;
      r_y          <= '0;
      r_addr       <= '0;
      r_lcd_q      <= 1'b0;
      r_done_pend  <= 1'b0;
      r_ld         <= '0;
      r_px_valid   <= 1'b0;
      r_wr_addr    <= '0;
      r_frame_done <= 1'b0;
      r_err_sticky <= 1'b0;
    end else begin
      r_lcd_q      <= lcd_en;
      r_px_valid   <= 1'b0;
      r_done_pend  <= 1'b0;
      r_frame_done <= r_done_pend;
      if (w_err_evt) r_err_sticky <= 1'b1;

      if (w_fall) begin
        r_state <= S_BLANK;
        r_x     <= '0;
        r_y     <= '0;
        r_addr  <= '0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (frame_start && lcd_en) begin
              r_state <= S_ACTIVE;
              r_x     <= '0;
              r_y     <= '0;
              r_addr  <= '0;
            end
          end
          S_ACTIVE: begin
            if (frame_start) begin
              r_x    <= '0;
              r_y    <= '0;
              r_addr <= '0;
            end else begin
              if (w_take) begin
                r_ld       <= pix_in;
                r_px_valid <= 1'b1;
                r_wr_addr  <= r_addr;
                r_addr     <= r_addr + LP_A_ONE;
              end
              // The last line has no following line_start, so it closes on its final pixel.
              if (w_frame_full) begin
                r_done_pend <= 1'b1;
                r_state     <= S_IDLE;
                r_x         <= w_x_nxt;
              end else if (line_start && w_line_full) begin
                r_x <= '0;
                r_y <= r_y + LP_Y_ONE;
              end else begin
                r_x <= w_x_nxt;
                if (w_pad_entry) r_state <= S_PAD;
              end
            end
          end
          S_PAD: begin
            if (frame_start) begin
              r_state <= S_ACTIVE;
              r_x     <= '0;
              r_y     <= '0;
              r_addr  <= '0;
            end else begin
              r_ld       <= PAD_SHADE;
              r_px_valid <= 1'b1;
              r_wr_addr  <= r_addr;
              r_addr     <= r_addr + LP_A_ONE;
              if (r_x == LP_X_LAST) begin
                r_x <= '0;
                if (r_y == LP_Y_LAST) begin
                  r_done_pend <= 1'b1;
                  r_state     <= S_IDLE;
                end else begin
                  r_y     <= r_y + LP_Y_ONE;
                  r_state <= S_ACTIVE;
                end
              end else begin
                r_x <= r_x + LP_X_ONE;
              end
            end
          end
          default: begin
            r_ld       <= PAD_SHADE;
            r_px_valid <= 1'b1;
            r_wr_addr  <= r_addr;
            if (r_addr == LP_A_LAST) begin
              r_addr      <= '0;
              r_done_pend <= 1'b1;
              r_state     <= S_IDLE;
            end else begin
              r_addr <= r_addr + LP_A_ONE;
            end
          end
        endcase
      end
    end
  end

`ifdef GB_LCD_FRAME_WRITER_ERRCNT_EN
  logic [7:0] r_err_count;

  always_ff @(posedge GameBoy_clk or posedge GameBoy_reset) begin
    if (GameBoy_reset) begin
      r_err_count <= '0;
    end else if (w_err_evt && (r_err_count != 8'hFF)) begin
      r_err_count <= r_err_count + 8'd1;
    end
  end

  assign err_count = r_err_count;
`endif

  assign LD         = r_ld;
  assign PX_VALID   = r_px_valid;
  assign WR_ADDR    = r_wr_addr;
  assign frame_done = r_frame_done;
  assign err_sticky = r_err_sticky;

endmodule
